// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operation sequencer and its combinational ALU.
//   DATA_W   : operand/result width (only 6 is supported)
//   FXN_*    : 3-bit ALU function codes
//   state_e  : sequencer state encoding
package alu_pkg;

   localparam int unsigned DATA_W = 6;

   localparam logic [2:0] FXN_PASS_A = 3'b000;
   localparam logic [2:0] FXN_PASS_B = 3'b001;
   localparam logic [2:0] FXN_NEG_A  = 3'b010;
   localparam logic [2:0] FXN_NEG_B  = 3'b011;
   localparam logic [2:0] FXN_SLT    = 3'b100;
   localparam logic [2:0] FXN_XNOR   = 3'b101;
   localparam logic [2:0] FXN_ADD    = 3'b110;
   localparam logic [2:0] FXN_SUB    = 3'b111;

   localparam logic [2:0] ST_LOAD_A = 3'd0;
   localparam logic [2:0] ST_LOAD_B = 3'd1;
   localparam logic [2:0] ST_LOAD_F = 3'd2;
   localparam logic [2:0] ST_EXEC   = 3'd3;
   localparam logic [2:0] ST_DONE   = 3'd4;

   typedef enum logic [2:0] {
      StLoadA = ST_LOAD_A,
      StLoadB = ST_LOAD_B,
      StLoadF = ST_LOAD_F,
      StExec  = ST_EXEC,
      StDone  = ST_DONE
   } state_e;

endpackage

// File: rtl/alu_op_sequencer_alu.sv
// Alu_top: purely combinational 6-bit ALU.
//   a, b : operands (two's complement)
//   fxn  : function code (see alu_pkg FXN_*)
//   x    : result
module Alu_top
   import alu_pkg::*;
(
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [2:0]        fxn,
   output logic [DATA_W-1:0] x
);

   always_comb begin
      x = '0;
      unique case (fxn)
         FXN_PASS_A: x = a;
         FXN_PASS_B: x = b;
         FXN_NEG_A:  x = -a;
         FXN_NEG_B:  x = -b;
         FXN_SLT:    x = ($signed(a) < $signed(b)) ? DATA_W'(1) : '0;
         FXN_XNOR:   x = ~(a ^ b);
         FXN_ADD:    x = a + b;
         FXN_SUB:    x = a - b;
      endcase
   end

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: collects A, B and a function code over a valid/ready input
// stream, runs them through Alu_top for one cycle, and presents the registered
// result with zero/negative/overflow flags on a valid/ready output stream.
//   clk, rst_n          : clock, asynchronous active-low reset
//   clr                 : synchronous abort back to operand-A entry
//   in_valid/in_ready   : input handshake; in_data carries A, B, then fxn in [2:0]
//   out_valid/out_ready : output handshake for result and flags
//   result, flag_*      : registered ALU output and status
//   op_count            : number of results handed off (wrapping)
module alu_op_sequencer
   import alu_pkg::*;
#(
   parameter int unsigned DATA_W = alu_pkg::DATA_W,
   parameter int unsigned CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] result,
   output logic              flag_zero,
   output logic              flag_neg,
   output logic              flag_ovf,
   output logic [CNT_W-1:0]  op_count
);

   state_e state_q, state_d;

   logic [DATA_W-1:0] a_q, b_q, result_q;
   logic [2:0]        fxn_q;
   logic              zero_q, neg_q, ovf_q;
   logic [CNT_W-1:0]  count_q;

   logic [DATA_W-1:0] alu_x;
   logic              ovf_d;
   logic              in_hs, out_hs;

   localparam logic [DATA_W-1:0] MinNeg = {1'b1, {(DATA_W-1){1'b0}}};

   Alu_top u_alu (
      .a   (a_q),
      .b   (b_q),
      .fxn (fxn_q),
      .x   (alu_x)
   );

   assign in_ready  = (state_q == StLoadA) || (state_q == StLoadB) || (state_q == StLoadF);
   assign out_valid = (state_q == StDone);
   assign in_hs     = in_valid & in_ready;
   assign out_hs    = out_valid & out_ready;

   always_comb begin
      state_d = state_q;
      if (clr) begin
         state_d = StLoadA;
      end else begin
         unique case (state_q)
            StLoadA: if (in_hs)  state_d = StLoadB;
            StLoadB: if (in_hs)  state_d = StLoadF;
            StLoadF: if (in_hs)  state_d = StExec;
            StExec:              state_d = StDone;
            StDone:  if (out_hs) state_d = StLoadA;
            default:             state_d = StLoadA;
         endcase
      end
   end

   // Signed overflow from the registered operands and the live ALU output.
   always_comb begin
      ovf_d = 1'b0;
      unique case (fxn_q)
         FXN_NEG_A: ovf_d = (a_q == MinNeg);
         FXN_NEG_B: ovf_d = (b_q == MinNeg);
         FXN_ADD:   ovf_d = (a_q[DATA_W-1] == b_q[DATA_W-1]) &&
                            (alu_x[DATA_W-1] != a_q[DATA_W-1]);
         FXN_SUB:   ovf_d = (a_q[DATA_W-1] != b_q[DATA_W-1]) &&
                            (alu_x[DATA_W-1] != a_q[DATA_W-1]);
         default:   ovf_d = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StLoadA;
         a_q      <= '0;
         b_q      <= '0;
         fxn_q    <= '0;
         result_q <= '0;
         zero_q   <= 1'b0;
         neg_q    <= 1'b0;
         ovf_q    <= 1'b0;
         count_q  <= '0;
      end else begin
         state_q <= state_d;
         // clr freezes every data register; only the state returns to LOAD_A.
         if (!clr) begin
            if (state_q == StLoadA && in_hs) a_q   <= in_data;
            if (state_q == StLoadB && in_hs) b_q   <= in_data;
            if (state_q == StLoadF && in_hs) fxn_q <= in_data[2:0];
            if (state_q == StExec) begin
               result_q <= alu_x;
               zero_q   <= (alu_x == '0);
               neg_q    <= alu_x[DATA_W-1];
               ovf_q    <= ovf_d;
            end
            if (out_hs) count_q <= count_q + CNT_W'(1);
         end
      end
   end

   assign result    = result_q;
   assign flag_zero = zero_q;
   assign flag_neg  = neg_q;
   assign flag_ovf  = ovf_q;
   assign op_count  = count_q;

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Sequential front/back end for the existing 6-bit combinational Alu_top.
- Collects operand A, operand B and function code one word at a time over a valid/ready input stream, then executes through an internal Alu_top instance.
- Registers the result with status flags and presents it on a valid/ready output stream.
- Sits between the board-level operand entry logic (switch/keypad debouncer) and the display/result consumer.

Parameters:
- DATA_W, 6, operand/result width; must equal Alu_top width. 6 is the only supported value.
- CNT_W, 8, width of the completed-operation counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous abort; returns to LOAD_A and discards partial entry.
- in_valid  in  1  in_data is valid this cycle.
- in_ready  out  1  block accepts in_data this cycle.
- in_data  in  DATA_W  operand word, or function code in bits [2:0].
- out_valid  out  1  result registers hold a valid result.
- out_ready  in  1  consumer accepts the result.
- result  out  DATA_W  registered Alu_top X.
- flag_zero  out  1  result == 0.
- flag_neg  out  1  result[DATA_W-1].
- flag_ovf  out  1  two's-complement overflow, per the rules below.
- op_count  out  CNT_W  completed (handed-off) operations.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to LOAD_A.
  - Registers A_reg, B_reg, fxn_reg, result, all flags and op_count go to 0.
  - out_valid = 0; in_ready = 1 after release.
  - Reset mid-operation discards everything; no partial result is ever emitted.
- States: LOAD_A, LOAD_B, LOAD_F, EXEC, DONE.
- in_ready is high only in LOAD_A, LOAD_B and LOAD_F. A handshake is in_valid & in_ready at a rising edge.
- LOAD_A: handshake captures in_data into A_reg, then go to LOAD_B.
- LOAD_B: handshake captures B_reg, then go to LOAD_F.
- LOAD_F: handshake captures in_data[2:0] into fxn_reg and ignores bits [5:3], then go to EXEC.
- EXEC (exactly one cycle):
  - Alu_top is driven from A_reg, B_reg and fxn_reg.
  - At the closing edge, X loads into result, flags are computed from the registered operands and X, and state goes to DONE.
- DONE:
  - out_valid = 1.
  - result and flags are held stable until out_ready is sampled high.
  - On handshake: out_valid drops next cycle, op_count increments (wraps 2^CNT_W-1 -> 0), and state goes to LOAD_A.
  - No input bypass: in_ready = 0 throughout DONE.
- Latency: fxn handshake in cycle c, EXEC in c+1, out_valid high from c+2. Best-case throughput is 1 operation per 5 cycles.
- Function codes: 000 A, 001 B, 010 -A, 011 -B, 100 (A<B signed ? 1 : 0), 101 A xnor B, 110 A+B, 111 A-B.
- flag_ovf rules:
  - 010: set iff A = 100000.
  - 011: set iff B = 100000.
  - 110: set iff sign(A) = sign(B) and sign(X) != sign(A).
  - 111: set iff sign(A) != sign(B) and sign(X) != sign(A).
  - All other codes: 0.
- flag_zero and flag_neg derive from the result for every code.
- clr:
  - Takes priority over every handshake in the same cycle.
  - Next state is LOAD_A and out_valid goes to 0.
  - A_reg, B_reg, fxn_reg and the result/flag registers keep their values.
  - op_count is unchanged.
- in_valid arriving while in_ready = 0 is ignored. The upstream source must hold its data.

Decomposition:
- Shared package alu_pkg:
  - DATA_W.
  - FXN_* localparams for the eight codes.
  - State encoding constants for the five states.
- One sub-module: the existing Alu_top, instantiated unchanged as u_alu.
- Overflow/flag logic stays inline in alu_op_sequencer.

Test Plan:
- Load A=000011, B=100011 (-29), fxn=110 with out_ready=1 -> result=100110 (-26), neg=1, zero=0, ovf=0; out_valid exactly 2 cycles after fxn handshake; op_count=1.
- Load A=011111, B=000001, fxn=110 -> result=100000, ovf=1, neg=1. Then A=100000, fxn=010 -> result=100000, ovf=1.
- Load A=101111 (-17), B=101100 (-20), fxn=111 -> result=000011, ovf=0, neg=0. Then A=1, B=1, fxn=100 -> result=000000, zero=1.
- Hold out_ready=0 for 5 cycles in DONE with in_valid=1 -> result/flags/out_valid stable, in_ready=0, no operand captured. Release out_ready -> LOAD_A on next cycle.
- Assert rst_n=0 asynchronously mid-LOAD_F, and separately pulse clr in LOAD_B -> reset: all outputs 0, op_count=0; clr: back to LOAD_A, op_count unchanged, no out_valid.
- Run 256 operations -> op_count wraps to 0.
